// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register for the pipelined MIPS core.
// Captures a decoded instruction for EX, bypasses same-cycle write-back data
// onto register-bank reads, inserts a bubble on load-use hazards, and honours
// flush (branch resolution) and stall (downstream back-pressure).
module id_ex_pipeline_reg #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      id_valid,
   input  logic [REG_ADDR_WIDTH-1:0] id_read_register_1,
   input  logic [REG_ADDR_WIDTH-1:0] id_read_register_2,
   input  logic [REG_ADDR_WIDTH-1:0] id_rd,
   input  logic [DATA_WIDTH-1:0]     id_read_data_1,
   input  logic [DATA_WIDTH-1:0]     id_read_data_2,
   input  logic [DATA_WIDTH-1:0]     id_imm,
   input  logic [DATA_WIDTH-1:0]     id_pc_plus4,
   input  logic                      id_regWrite,
   input  logic                      id_memRead,
   input  logic                      id_memWrite,
   input  logic                      id_memToReg,
   input  logic                      id_aluSrc,
   input  logic                      id_regDst,
   input  logic [3:0]                id_alu_op,
   input  logic                      wb_regWrite,
   input  logic [REG_ADDR_WIDTH-1:0] wb_write_register,
   input  logic [DATA_WIDTH-1:0]     wb_write_data,
   input  logic                      flush,
   input  logic                      ex_stall,
   output logic                      id_hold,
   output logic                      ex_valid,
   output logic [REG_ADDR_WIDTH-1:0] ex_read_register_1,
   output logic [REG_ADDR_WIDTH-1:0] ex_read_register_2,
   output logic [REG_ADDR_WIDTH-1:0] ex_write_register,
   output logic [DATA_WIDTH-1:0]     ex_read_data_1,
   output logic [DATA_WIDTH-1:0]     ex_read_data_2,
   output logic [DATA_WIDTH-1:0]     ex_imm,
   output logic [DATA_WIDTH-1:0]     ex_pc_plus4,
   output logic                      ex_regWrite,
   output logic                      ex_memRead,
   output logic                      ex_memWrite,
   output logic                      ex_memToReg,
   output logic                      ex_aluSrc,
   output logic [3:0]                ex_alu_op
);

   typedef struct packed {
      logic                      valid;
      logic [REG_ADDR_WIDTH-1:0] rs;
      logic [REG_ADDR_WIDTH-1:0] rt;
      logic [REG_ADDR_WIDTH-1:0] wr;
      logic [DATA_WIDTH-1:0]     d1;
      logic [DATA_WIDTH-1:0]     d2;
      logic [DATA_WIDTH-1:0]     imm;
      logic [DATA_WIDTH-1:0]     pc;
      logic                      reg_write;
      logic                      mem_read;
      logic                      mem_write;
      logic                      mem_to_reg;
      logic                      alu_src;
      logic [3:0]                alu_op;
   } ex_slot_t;

   ex_slot_t ex_q;
   ex_slot_t cap;
   ex_slot_t held;
   logic     load_use;

   // r0 is hard-wired zero, so a write-back aimed at it must never leak through.
   function automatic logic [DATA_WIDTH-1:0] byp(
      input logic [REG_ADDR_WIDTH-1:0] r,
      input logic [DATA_WIDTH-1:0]     d,
      input logic                      we,
      input logic [REG_ADDR_WIDTH-1:0] wr,
      input logic [DATA_WIDTH-1:0]     wd
   );
      if (r == '0)               return '0;
      else if (we && (wr == r))  return wd;
      else                       return d;
   endfunction

   // Hazard detect: rt is compared even for instructions that do not read it.
   always_comb begin
      load_use = ex_q.valid && ex_q.mem_read && (ex_q.wr != '0) && id_valid &&
                 ((ex_q.wr == id_read_register_1) || (ex_q.wr == id_read_register_2));
      id_hold  = !flush && (ex_stall || load_use);
   end

   // Candidate next contents: a fresh capture from ID, or the held slot with
   // its operands refreshed by any write-back that lands while stalled.
   always_comb begin
      cap            = '0;
      cap.valid      = id_valid;
      cap.rs         = id_read_register_1;
      cap.rt         = id_read_register_2;
      cap.wr         = id_regDst ? id_rd : id_read_register_2;
      cap.d1         = byp(id_read_register_1, id_read_data_1,
                           wb_regWrite, wb_write_register, wb_write_data);
      cap.d2         = byp(id_read_register_2, id_read_data_2,
                           wb_regWrite, wb_write_register, wb_write_data);
      cap.imm        = id_imm;
      cap.pc         = id_pc_plus4;
      cap.reg_write  = id_valid & id_regWrite;
      cap.mem_read   = id_valid & id_memRead;
      cap.mem_write  = id_valid & id_memWrite;
      cap.mem_to_reg = id_valid & id_memToReg;
      cap.alu_src    = id_valid & id_aluSrc;
      cap.alu_op     = id_valid ? id_alu_op : 4'd0;

      held           = ex_q;
      held.d1        = byp(ex_q.rs, ex_q.d1, wb_regWrite, wb_write_register, wb_write_data);
      held.d2        = byp(ex_q.rt, ex_q.d2, wb_regWrite, wb_write_register, wb_write_data);
   end

   // Slot update: flush beats stall, stall beats the load-use bubble.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)         ex_q <= '0;
      else if (flush)    ex_q <= '0;
      else if (ex_stall) ex_q <= held;
      else if (load_use) ex_q <= '0;
      else               ex_q <= cap;
   end

   assign ex_valid           = ex_q.valid;
   assign ex_read_register_1 = ex_q.rs;
   assign ex_read_register_2 = ex_q.rt;
   assign ex_write_register  = ex_q.wr;
   assign ex_read_data_1     = ex_q.d1;
   assign ex_read_data_2     = ex_q.d2;
   assign ex_imm             = ex_q.imm;
   assign ex_pc_plus4        = ex_q.pc;
   assign ex_regWrite        = ex_q.reg_write;
   assign ex_memRead         = ex_q.mem_read;
   assign ex_memWrite        = ex_q.mem_write;
   assign ex_memToReg        = ex_q.mem_to_reg;
   assign ex_aluSrc          = ex_q.alu_src;
   assign ex_alu_op          = ex_q.alu_op;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Scoreboard bench for id_ex_pipeline_reg. The bench owns an architectural
// register file that feeds the ID read ports; the expected EX operand is
// simply the architectural value of the register once this cycle's
// write-back has landed.
module tb_id_ex_pipeline_reg;

   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid;
   logic [4:0]  id_read_register_1, id_read_register_2, id_rd;
   logic [31:0] id_read_data_1, id_read_data_2, id_imm, id_pc_plus4;
   logic        id_regWrite, id_memRead, id_memWrite, id_memToReg, id_aluSrc, id_regDst;
   logic [3:0]  id_alu_op;
   logic        wb_regWrite;
   logic [4:0]  wb_write_register;
   logic [31:0] wb_write_data;
   logic        flush, ex_stall;
   logic        id_hold, ex_valid;
   logic [4:0]  ex_read_register_1, ex_read_register_2, ex_write_register;
   logic [31:0] ex_read_data_1, ex_read_data_2, ex_imm, ex_pc_plus4;
   logic        ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg, ex_aluSrc;
   logic [3:0]  ex_alu_op;

   id_ex_pipeline_reg dut (
      .clk(clk), .reset(reset), .id_valid(id_valid),
      .id_read_register_1(id_read_register_1), .id_read_register_2(id_read_register_2),
      .id_rd(id_rd), .id_read_data_1(id_read_data_1), .id_read_data_2(id_read_data_2),
      .id_imm(id_imm), .id_pc_plus4(id_pc_plus4),
      .id_regWrite(id_regWrite), .id_memRead(id_memRead), .id_memWrite(id_memWrite),
      .id_memToReg(id_memToReg), .id_aluSrc(id_aluSrc), .id_regDst(id_regDst),
      .id_alu_op(id_alu_op), .wb_regWrite(wb_regWrite),
      .wb_write_register(wb_write_register), .wb_write_data(wb_write_data),
      .flush(flush), .ex_stall(ex_stall), .id_hold(id_hold), .ex_valid(ex_valid),
      .ex_read_register_1(ex_read_register_1), .ex_read_register_2(ex_read_register_2),
      .ex_write_register(ex_write_register), .ex_read_data_1(ex_read_data_1),
      .ex_read_data_2(ex_read_data_2), .ex_imm(ex_imm), .ex_pc_plus4(ex_pc_plus4),
      .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite),
      .ex_memToReg(ex_memToReg), .ex_aluSrc(ex_aluSrc), .ex_alu_op(ex_alu_op)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        valid;
      logic [4:0]  rs, rt, wr;
      logic [31:0] d1, d2, imm, pc;
      logic        rw, mr, mw, m2r, as;
      logic [3:0]  op;
   } ex_t;

   typedef struct packed {
      logic hold;
      ex_t  ex;
   } exp_t;

   typedef struct {
      logic        id_valid;
      logic [4:0]  rs, rt, rd;
      logic [31:0] imm, pc;
      logic        rw, mr, mw, m2r, as, rdst;
      logic [3:0]  op;
      logic        wb_we;
      logic [4:0]  wb_wr;
      logic [31:0] wb_data;
      logic        flush, stall;
      logic        junk0;   // drive garbage on reads of r0
   } stim_t;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] rf [32];
   ex_t         m;          // model of the EX slot
   logic        last_hold = 1'b0;
   exp_t        exp_q [$];

   function automatic ex_t dut_ex();
      return {ex_valid, ex_read_register_1, ex_read_register_2, ex_write_register,
              ex_read_data_1, ex_read_data_2, ex_imm, ex_pc_plus4,
              ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg, ex_aluSrc, ex_alu_op};
   endfunction

   function automatic stim_t idle();
      stim_t s;
      s = '{id_valid: 1'b0, rs: 5'd0, rt: 5'd0, rd: 5'd0, imm: 32'd0, pc: 32'd0,
            rw: 1'b0, mr: 1'b0, mw: 1'b0, m2r: 1'b0, as: 1'b0, rdst: 1'b0, op: 4'd0,
            wb_we: 1'b0, wb_wr: 5'd0, wb_data: 32'd0, flush: 1'b0, stall: 1'b0,
            junk0: 1'b0};
      return s;
   endfunction

   function automatic stim_t rand_stim();
      stim_t s;
      s.id_valid = ($urandom_range(0, 9) < 8);
      s.rs = 5'($urandom_range(0, 7));  s.rt = 5'($urandom_range(0, 7));
      s.rd = 5'($urandom_range(0, 7));
      s.imm = $urandom;  s.pc = $urandom;
      s.rw = 1'($urandom_range(0, 1));  s.mr = ($urandom_range(0, 9) < 4);
      s.mw = 1'($urandom_range(0, 1));  s.m2r = 1'($urandom_range(0, 1));
      s.as = 1'($urandom_range(0, 1));  s.rdst = 1'($urandom_range(0, 1));
      s.op = 4'($urandom_range(0, 15));
      s.wb_we = 1'($urandom_range(0, 1));  s.wb_wr = 5'($urandom_range(0, 7));
      s.wb_data = $urandom;
      s.flush = ($urandom_range(0, 9) == 0);  s.stall = ($urandom_range(0, 5) == 0);
      s.junk0 = 1'($urandom_range(0, 1));
      return s;
   endfunction

   // Architectural value of r as seen after this cycle's write-back.
   function automatic logic [31:0] arch(input stim_t s, input logic [4:0] r);
      if (r == 5'd0) return 32'd0;
      if (s.wb_we && s.wb_wr == r) return s.wb_data;
      return rf[r];
   endfunction

   // Apply one cycle of stimulus at a falling edge, predict, then advance.
   task automatic cycle(input stim_t s);
      logic lu, hold;
      exp_t e;
      id_valid = s.id_valid;  id_read_register_1 = s.rs;  id_read_register_2 = s.rt;
      id_rd = s.rd;  id_imm = s.imm;  id_pc_plus4 = s.pc;
      id_read_data_1 = (s.rs == 5'd0 && s.junk0) ? $urandom : rf[s.rs];
      id_read_data_2 = (s.rt == 5'd0 && s.junk0) ? $urandom : rf[s.rt];
      id_regWrite = s.rw;  id_memRead = s.mr;  id_memWrite = s.mw;
      id_memToReg = s.m2r;  id_aluSrc = s.as;  id_regDst = s.rdst;  id_alu_op = s.op;
      wb_regWrite = s.wb_we;  wb_write_register = s.wb_wr;  wb_write_data = s.wb_data;
      flush = s.flush;  ex_stall = s.stall;

      lu   = m.valid && m.mr && (m.wr != 5'd0) && s.id_valid && (m.wr == s.rs || m.wr == s.rt);
      hold = !s.flush && (s.stall || lu);
      if (s.flush || (!s.stall && lu)) begin
         m = '0;
      end else if (s.stall) begin
         m.d1 = arch(s, m.rs);
         m.d2 = arch(s, m.rt);
      end else begin
         m.valid = s.id_valid;
         m.rs = s.rs;  m.rt = s.rt;  m.wr = s.rdst ? s.rd : s.rt;
         m.d1 = arch(s, s.rs);  m.d2 = arch(s, s.rt);
         m.imm = s.imm;  m.pc = s.pc;
         m.rw  = s.id_valid && s.rw;   m.mr = s.id_valid && s.mr;
         m.mw  = s.id_valid && s.mw;   m.m2r = s.id_valid && s.m2r;
         m.as  = s.id_valid && s.as;   m.op = s.id_valid ? s.op : 4'd0;
      end
      e.hold = hold;
      e.ex   = m;
      exp_q.push_back(e);
      if (s.wb_we && s.wb_wr != 5'd0) rf[s.wb_wr] = s.wb_data;
      last_hold = hold;
      @(negedge clk);
   endtask

   // Reset asserted between edges; outputs must clear without a clock.
   task automatic async_reset(input string name);
      ex_t act;
      #2 reset = 1'b1;
      #1 act = dut_ex();
      checks++;
      if (act !== ex_t'('0)) begin
         errors++;
         $display("FAIL %s: got %h expected 0", name, act);
      end
      m = '0;
      last_hold = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Monitor: id_hold just before the edge, EX slot just after it.
   initial begin
      exp_t e;
      ex_t  act;
      forever begin
         @(negedge clk);
         #4;
         if (exp_q.size() == 0) continue;
         e = exp_q[0];
         checks++;
         if (id_hold !== e.hold) begin
            errors++;
            $display("FAIL id_hold @%0t: got %b expected %b", $time, id_hold, e.hold);
         end
         @(posedge clk);
         #1;
         act = dut_ex();
         checks++;
         if (act !== e.ex) begin
            errors++;
            $display("FAIL ex_slot @%0t: got %h expected %h", $time, act, e.ex);
         end
         void'(exp_q.pop_front());
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      stim_t s, prev;
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      rf[0] = 32'd0;  rf[1] = 32'd5;  rf[2] = 32'd9;
      m = '0;
      reset = 1'b1;
      s = idle();
      id_valid = 0; id_read_register_1 = 0; id_read_register_2 = 0; id_rd = 0;
      id_read_data_1 = 0; id_read_data_2 = 0; id_imm = 0; id_pc_plus4 = 0;
      id_regWrite = 0; id_memRead = 0; id_memWrite = 0; id_memToReg = 0;
      id_aluSrc = 0; id_regDst = 0; id_alu_op = 0; wb_regWrite = 0;
      wb_write_register = 0; wb_write_data = 0; flush = 0; ex_stall = 0;
      repeat (2) @(negedge clk);
      checks++;
      if (dut_ex() !== ex_t'('0) || id_hold !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got %h hold %b expected 0", dut_ex(), id_hold);
      end
      reset = 1'b0;

      // Basic capture: rs=1 (5), rt=2 (9), rd=3 with regDst.
      s = idle(); s.id_valid = 1; s.rs = 1; s.rt = 2; s.rd = 3; s.rdst = 1;
      s.op = 4'd2; s.rw = 1; s.imm = 32'h10; s.pc = 32'h104;
      cycle(s);
      async_reset("async_reset");

      // Write-back bypass onto r2, then a write-back to r0 that must not bypass.
      s = idle(); s.id_valid = 1; s.rs = 2; s.wb_we = 1; s.wb_wr = 2; s.wb_data = 32'd7;
      cycle(s);
      s = idle(); s.id_valid = 1; s.rs = 0; s.wb_we = 1; s.wb_wr = 0; s.wb_data = 32'd7;
      s.junk0 = 1;
      cycle(s);

      // Load-use: lw to r4, then add reading r4 is held one cycle then captured.
      s = idle(); s.id_valid = 1; s.rs = 1; s.rt = 4; s.mr = 1; s.rw = 1; s.m2r = 1; s.as = 1;
      cycle(s);
      s = idle(); s.id_valid = 1; s.rs = 4; s.rt = 6; s.rd = 7; s.rdst = 1; s.rw = 1; s.op = 4'd2;
      cycle(s);
      cycle(s);

      // Stall with an operand refreshed by write-back mid-stall.
      s = idle(); s.id_valid = 1; s.rs = 5; s.rt = 3; s.rw = 1; s.op = 4'd5; s.pc = 32'h200;
      cycle(s);
      s = idle(); s.id_valid = 1; s.rs = 1; s.stall = 1;
      cycle(s);
      s.wb_we = 1; s.wb_wr = 5; s.wb_data = 32'h1234;
      cycle(s);
      s.wb_we = 0;
      cycle(s);

      // Flush beats stall and a live load-use hazard.
      s = idle(); s.id_valid = 1; s.rt = 4; s.mr = 1; s.rw = 1;
      cycle(s);
      s = idle(); s.id_valid = 1; s.rs = 4; s.rw = 1; s.flush = 1; s.stall = 1;
      cycle(s);

      // Invalid decode slot with regWrite set.
      s = idle(); s.id_valid = 0; s.rw = 1; s.mr = 1; s.mw = 1; s.rs = 3;
      cycle(s);

      // Randomized traffic; ID repeats its instruction while held.
      prev = idle();
      for (int n = 0; n < 1500; n++) begin
         s = rand_stim();
         if (last_hold) begin
            s.id_valid = prev.id_valid; s.rs = prev.rs; s.rt = prev.rt; s.rd = prev.rd;
            s.imm = prev.imm; s.pc = prev.pc; s.rw = prev.rw; s.mr = prev.mr;
            s.mw = prev.mw; s.m2r = prev.m2r; s.as = prev.as; s.rdst = prev.rdst;
            s.op = prev.op;
         end
         prev = s;
         cycle(s);
         if (n == 700) async_reset("async_reset_mid");
      end

      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
